// File: rtl/bfsk_pkg.sv
// -----------------------------------------------------------------------------
// bfsk_pkg
// Shared definitions for the BFSK modulator / demodulator pair.
//   - tx_state_t       : framing FSM states (IDLE, START, DATA, STOP)
//   - START/STOP/IDLE  : line levels of the framing bits
//   - phase_inc()      : NCO phase increment for a tone, rounded to nearest
//   - samples_per_bit(): samples per symbol, rounded to nearest
//   - sine_lut_entry() : elaboration-time offset-binary sine table entry
// -----------------------------------------------------------------------------
package bfsk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_BIT  = 1'b1;

  localparam real PI = 3.141592653589793;

  // Round half away from zero; $rtoi alone truncates.
  function automatic longint round_real(input real x);
    if (x >= 0.0) begin
      return longint'($rtoi(x + 0.5));
    end else begin
      return -longint'($rtoi(0.5 - x));
    end
  endfunction

  // round(f * 2^acc_w / fs)
  function automatic longint phase_inc(input real f, input real fs, input int acc_w);
    real scale;
    scale = 1.0;
    for (int i = 0; i < acc_w; i++) begin
      scale = scale * 2.0;
    end
    return round_real(f * scale / fs);
  endfunction

  // round(fs / baud)
  function automatic int samples_per_bit(input real fs, input real baud);
    return int'(round_real(fs / baud));
  endfunction

  // Taylor series for sin(x), |x| <= pi; 20 terms is far below 1 LSB of error.
  function automatic real sin_series(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n < 20; n++) begin
      term = -term * x * x / ((2.0 * real'(n)) * (2.0 * real'(n) + 1.0));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // round((2^(sample_w-1)-1) * sin(2*pi*idx/2^addr_w)) + 2^(sample_w-1)
  function automatic int sine_lut_entry(input int idx, input int addr_w, input int sample_w);
    real angle;
    real amp;
    int  depth;
    int  mid;
    depth = 32'sd1 << addr_w;
    mid   = 32'sd1 << (sample_w - 1);
    angle = 2.0 * PI * real'(idx) / real'(depth);
    // Fold into [-pi, pi] where the series converges quickly.
    if (angle > PI) begin
      angle = angle - 2.0 * PI;
    end
    amp = real'(mid - 32'sd1);
    return int'(round_real(amp * sin_series(angle))) + mid;
  endfunction

endpackage

// File: rtl/bfsk_mod_if.sv
// -----------------------------------------------------------------------------
// bfsk_mod_if
// Generic valid/ready stream used for both the byte input and the sample
// output of the modulator.
//   valid : producer has data
//   ready : consumer accepts data (transfer on valid && ready)
//   data  : WIDTH-bit payload
// Modports: master = producer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface bfsk_mod_if #(
  parameter int WIDTH = 8
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/bfsk_nco.sv
// -----------------------------------------------------------------------------
// bfsk_nco
// Phase accumulator with registered sine lookup. On each advance the phase
// moves by inc (mod 2^ACC_WIDTH) and the sample register loads the LUT entry
// addressed by the top LUT_ADDR_WIDTH bits of the new phase, so sample always
// corresponds to the current phase. Both hold while advance is low.
//   clk, rst_n : clock, asynchronous active-low reset (phase 0, midscale out)
//   advance    : step the oscillator this cycle
//   inc        : phase increment for this step
//   sample     : offset-binary sine sample (registered)
// -----------------------------------------------------------------------------
module bfsk_nco
  import bfsk_pkg::*;
#(
  parameter int ACC_WIDTH      = 28,
  parameter int SAMPLE_WIDTH   = 12,
  parameter int LUT_ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    advance,
  input  logic [ACC_WIDTH-1:0]    inc,
  output logic [SAMPLE_WIDTH-1:0] sample
);

  localparam int LUT_DEPTH = 32'sd1 << LUT_ADDR_WIDTH;
  localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  logic [SAMPLE_WIDTH-1:0] lut_s [LUT_DEPTH];

  logic [ACC_WIDTH-1:0]    phase_d;
  logic [ACC_WIDTH-1:0]    phase_q;
  logic [SAMPLE_WIDTH-1:0] sample_d;
  logic [SAMPLE_WIDTH-1:0] sample_q;

  // Full-cycle sine table, every entry fixed at elaboration.
  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
    localparam logic [SAMPLE_WIDTH-1:0] ENTRY =
      SAMPLE_WIDTH'(sine_lut_entry(g, LUT_ADDR_WIDTH, SAMPLE_WIDTH));
    assign lut_s[g] = ENTRY;
  end

  // Next phase and the sample that goes with it.
  always_comb begin
    phase_d  = phase_q;
    sample_d = sample_q;
    if (advance) begin
      phase_d  = phase_q + inc;
      sample_d = lut_s[phase_d[ACC_WIDTH-1 -: LUT_ADDR_WIDTH]];
    end else begin
      phase_d  = phase_q;
      sample_d = sample_q;
    end
  end

  // Phase and sample registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= '0;
      sample_q <= MIDSCALE;
    end else begin
      phase_q  <= phase_d;
      sample_q <= sample_d;
    end
  end

  assign sample = sample_q;

endmodule

// File: rtl/bfsk_mod.sv
// -----------------------------------------------------------------------------
// bfsk_mod
// BFSK modulator. Bytes arriving on in_if are framed as one start bit,
// DATA_WIDTH data bits (LSB first) and one stop bit; each symbol lasts SPB
// accepted samples of a continuous-phase tone (F0 for 0, F1 for 1/idle).
// The sample stream never runs dry, so the downstream DAC FIFO paces
// everything through out_if.ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_if      : byte stream (slave)   valid / ready / data[DATA_WIDTH]
//   out_if     : sample stream (master) valid / ready / data[SAMPLE_WIDTH]
//   busy       : a frame is being transmitted
// -----------------------------------------------------------------------------
module bfsk_mod
  import bfsk_pkg::*;
#(
  parameter int  SAMPLE_WIDTH   = 12,
  parameter int  ACC_WIDTH      = 28,
  parameter int  DATA_WIDTH     = 8,
  parameter int  LUT_ADDR_WIDTH = 8,
  parameter real SAMPLE_RATE    = 48000.0,
  parameter real BAUD           = 45.0,
  parameter real F0             = 2995.0,
  parameter real F1             = 2125.0
) (
  input  logic        clk,
  input  logic        rst_n,
  bfsk_mod_if.slave   in_if,
  bfsk_mod_if.master  out_if,
  output logic        busy
);

  localparam int SPB   = samples_per_bit(SAMPLE_RATE, BAUD);
  localparam int CNT_W = (SPB > 1) ? $clog2(SPB) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [ACC_WIDTH-1:0] INC0     = ACC_WIDTH'(phase_inc(F0, SAMPLE_RATE, ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] INC1     = ACC_WIDTH'(phase_inc(F1, SAMPLE_RATE, ACC_WIDTH));
  localparam logic [CNT_W-1:0]     SPB_LAST = CNT_W'(SPB - 1);
  localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  tx_state_t             state_d;
  tx_state_t             state_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [BIT_W-1:0]      bit_idx_d;
  logic [BIT_W-1:0]      bit_idx_q;
  logic                  out_valid_d;
  logic                  out_valid_q;
  logic                  in_ready_d;
  logic                  in_ready_q;
  logic                  busy_d;
  logic                  busy_q;

  logic                  accept_s;
  logic                  sym_end_s;
  logic                  sym_bit_s;
  logic [ACC_WIDTH-1:0]  inc_s;

  assign accept_s  = out_valid_q && out_if.ready;
  assign sym_end_s = accept_s && (cnt_q == SPB_LAST);

  // Line level of the symbol currently on air.
  always_comb begin
    sym_bit_s = IDLE_BIT;
    case (state_q)
      IDLE:    sym_bit_s = IDLE_BIT;
      START:   sym_bit_s = START_BIT;
      DATA:    sym_bit_s = shift_q[0];
      STOP:    sym_bit_s = STOP_BIT;
      default: sym_bit_s = IDLE_BIT;
    endcase
  end

  assign inc_s = sym_bit_s ? INC1 : INC0;

  // Framing FSM: next state, shift register and bit index.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE: begin
        // in_ready is high exactly in IDLE, so in_valid alone is the handshake.
        if (in_if.valid) begin
          shift_d   = in_if.data;
          bit_idx_d = '0;
          state_d   = START;
        end else begin
          state_d   = IDLE;
        end
      end
      START: begin
        if (sym_end_s) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          state_d   = START;
        end
      end
      DATA: begin
        if (sym_end_s) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (sym_end_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Samples-per-symbol counter; parked at zero while idle so every frame
  // starts its start bit on a full symbol regardless of idle history.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (accept_s) begin
      if (sym_end_s) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Registered status outputs follow the next state.
  always_comb begin
    out_valid_d = 1'b1;
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  bfsk_nco #(
    .ACC_WIDTH      (ACC_WIDTH),
    .SAMPLE_WIDTH   (SAMPLE_WIDTH),
    .LUT_ADDR_WIDTH (LUT_ADDR_WIDTH)
  ) u_nco (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (accept_s),
    .inc     (inc_s),
    .sample  (out_if.data)
  );

  assign out_if.valid = out_valid_q;
  assign in_if.ready  = in_ready_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_bfsk_mod.sv
// -----------------------------------------------------------------------------
// tb_bfsk_mod
// Self-checking bench for bfsk_mod. The reference model holds the phase as a
// plain integer and a queue of per-sample phase increments: a byte handshake
// appends SPB increments per framing bit, every accepted sample pops one (or
// uses the mark increment when the queue is empty), and the expected sample
// is a $sin-derived table entry at the top address bits of the new phase.
// -----------------------------------------------------------------------------
module tb_bfsk_mod;

  localparam int          SPB   = 1067;
  localparam int          FRAME = 10670;
  localparam logic [27:0] INC0  = 28'd16749254;
  localparam logic [27:0] INC1  = 28'd11883861;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  bfsk_mod_if #(.WIDTH(8))  byte_if ();
  bfsk_mod_if #(.WIDTH(12)) smp_if ();

  bfsk_mod dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_if  (byte_if),
    .out_if (smp_if),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [11:0] lut [256];
  logic [27:0] m_p;
  logic [11:0] m_data;
  logic        m_valid;
  logic [27:0] m_q [$];
  bit          acc_f;
  bit          hs_f;

  task automatic model_reset();
    m_p     = 28'd0;
    m_data  = 12'd2048;
    m_valid = 1'b0;
    m_q.delete();
  endtask

  // One clock of stimulus plus model update; returns at the following negedge.
  task automatic tick();
    logic [27:0] inc;
    logic [7:0]  b;
    bit          lvl;
    acc_f = m_valid && smp_if.ready;
    hs_f  = (m_q.size() == 0) && byte_if.valid;
    b     = byte_if.data;
    @(posedge clk);
    if (acc_f) begin
      if (m_q.size() != 0) inc = m_q.pop_front();
      else                 inc = INC1;
      m_p    = m_p + inc;
      m_data = lut[m_p[27:20]];
    end
    if (hs_f) begin
      for (int s = 0; s < 10; s++) begin
        if (s == 0)      lvl = 1'b0;
        else if (s == 9) lvl = 1'b1;
        else             lvl = b[s-1];
        for (int k = 0; k < SPB; k++) m_q.push_back(lvl ? INC1 : INC0);
      end
    end
    m_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    byte_if.valid = 1'b0;
    byte_if.data  = 8'h00;
    smp_if.ready  = 1'b1;
    rst_n         = 1'b0;
    model_reset();
    @(negedge clk);
    vectors++; if (smp_if.valid !== 1'b0)    begin errors++; $display("FAIL rst_valid got %0d exp 0", smp_if.valid); end
    vectors++; if (smp_if.data !== 12'd2048) begin errors++; $display("FAIL rst_data got %0d exp 2048", smp_if.data); end
    vectors++; if (byte_if.ready !== 1'b1)   begin errors++; $display("FAIL rst_in_ready got %0d exp 1", byte_if.ready); end
    vectors++; if (busy !== 1'b0)            begin errors++; $display("FAIL rst_busy got %0d exp 0", busy); end
    rst_n = 1'b1;
    tick();
    vectors++; if (smp_if.valid !== 1'b1)    begin errors++; $display("FAIL first_valid got %0d exp 1", smp_if.valid); end
    vectors++; if (smp_if.data !== 12'd2048) begin errors++; $display("FAIL first_data got %0d exp 2048", smp_if.data); end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 60; c++) begin
      tick();
      vectors++; if (smp_if.data !== m_data) begin errors++; $display("FAIL idle_data cyc %0d got %0d exp %0d", c, smp_if.data, m_data); end
      vectors++; if (byte_if.ready !== 1'b1 || busy !== 1'b0 || smp_if.valid !== 1'b1) begin
        errors++; $display("FAIL idle_flags cyc %0d got rdy=%0d busy=%0d vld=%0d exp 1 0 1", c, byte_if.ready, busy, smp_if.valid);
      end
    end
  endtask

  task automatic test_phase_wrap();
    logic [27:0] prev;
    int          after;
    after = -1;
    for (int c = 0; c < 200 && after < 23; c++) begin
      prev = m_p;
      tick();
      if (after >= 0) after++;
      else if (m_p < prev) after = 0;
      vectors++; if (smp_if.data !== m_data) begin errors++; $display("FAIL wrap_data cyc %0d got %0d exp %0d", c, smp_if.data, m_data); end
    end
    vectors++; if (after < 23) begin errors++; $display("FAIL wrap_reached got %0d exp 23", after); end
  endtask

  // One frame; with random_ready the DAC accepts ~30% of cycles.
  task automatic test_frame(input logic [7:0] b, input bit random_ready, input string tag);
    int          n;
    bit          started;
    bit          done;
    logic [11:0] prev;
    n       = 0;
    started = 1'b0;
    done    = 1'b0;
    byte_if.valid = 1'b1;
    byte_if.data  = b;
    for (int c = 0; c < FRAME * 4 + 200 && !done; c++) begin
      if (random_ready) smp_if.ready = ($urandom_range(0, 9) < 3);
      prev = smp_if.data;
      tick();
      if (hs_f) begin
        started       = 1'b1;
        byte_if.valid = 1'b0;
      end else if (started && acc_f) begin
        n++;
      end
      vectors++; if (smp_if.data !== m_data) begin errors++; $display("FAIL %s_data cyc %0d got %0d exp %0d", tag, c, smp_if.data, m_data); end
      if (!acc_f) begin
        vectors++; if (smp_if.data !== prev) begin errors++; $display("FAIL %s_stall cyc %0d got %0d exp %0d", tag, c, smp_if.data, prev); end
      end
      vectors++; if (byte_if.ready !== (m_q.size() == 0)) begin errors++; $display("FAIL %s_in_ready cyc %0d got %0d exp %0d", tag, c, byte_if.ready, m_q.size() == 0); end
      vectors++; if (busy !== (m_q.size() != 0)) begin errors++; $display("FAIL %s_busy cyc %0d got %0d exp %0d", tag, c, busy, m_q.size() != 0); end
      if (started && busy === 1'b0) done = 1'b1;
    end
    smp_if.ready  = 1'b1;
    byte_if.valid = 1'b0;
    vectors++; if (!done || n != FRAME) begin errors++; $display("FAIL %s_len got %0d exp %0d (done=%0d)", tag, n, FRAME, done); end
  endtask

  task automatic test_back_to_back();
    int hs;
    bit done;
    hs   = 0;
    done = 1'b0;
    smp_if.ready  = 1'b1;
    byte_if.valid = 1'b1;
    byte_if.data  = 8'h00;
    for (int c = 0; c < FRAME * 2 + 200 && !done; c++) begin
      tick();
      if (hs_f) begin
        hs++;
        if (hs == 1) byte_if.data = 8'hFF;
        else         byte_if.valid = 1'b0;
      end
      vectors++; if (smp_if.data !== m_data) begin errors++; $display("FAIL b2b_data cyc %0d got %0d exp %0d", c, smp_if.data, m_data); end
      vectors++; if (byte_if.ready !== (m_q.size() == 0)) begin errors++; $display("FAIL b2b_in_ready cyc %0d got %0d exp %0d", c, byte_if.ready, m_q.size() == 0); end
      vectors++; if (busy !== (m_q.size() != 0)) begin errors++; $display("FAIL b2b_busy cyc %0d got %0d exp %0d", c, busy, m_q.size() != 0); end
      if (hs == 2 && busy === 1'b0) done = 1'b1;
    end
    byte_if.valid = 1'b0;
    vectors++; if (!done || hs != 2) begin errors++; $display("FAIL b2b_frames got %0d exp 2 (done=%0d)", hs, done); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit started;
    n       = 0;
    started = 1'b0;
    smp_if.ready  = 1'b1;
    byte_if.valid = 1'b1;
    byte_if.data  = 8'h3C;
    for (int c = 0; c < 3200 && n < 3000; c++) begin
      tick();
      if (hs_f) begin
        started       = 1'b1;
        byte_if.valid = 1'b0;
      end else if (started && acc_f) begin
        n++;
      end
    end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %0d exp 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (smp_if.valid !== 1'b0)    begin errors++; $display("FAIL mid_rst_valid got %0d exp 0", smp_if.valid); end
    vectors++; if (smp_if.data !== 12'd2048) begin errors++; $display("FAIL mid_rst_data got %0d exp 2048", smp_if.data); end
    vectors++; if (byte_if.ready !== 1'b1)   begin errors++; $display("FAIL mid_rst_in_ready got %0d exp 1", byte_if.ready); end
    vectors++; if (busy !== 1'b0)            begin errors++; $display("FAIL mid_rst_busy got %0d exp 0", busy); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      vectors++; if (smp_if.data !== m_data) begin errors++; $display("FAIL mid_idle_data cyc %0d got %0d exp %0d", c, smp_if.data, m_data); end
      vectors++; if (byte_if.ready !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL mid_idle_flags cyc %0d got rdy=%0d busy=%0d exp 1 0", c, byte_if.ready, busy);
      end
    end
  endtask

  initial begin
    real v;
    for (int i = 0; i < 256; i++) begin
      v = 2047.0 * $sin(2.0 * 3.141592653589793 * real'(i) / 256.0);
      if (v >= 0.0) lut[i] = 12'($rtoi(v + 0.5) + 2048);
      else          lut[i] = 12'(2048 - $rtoi(0.5 - v));
    end
    test_reset();
    test_idle();
    test_phase_wrap();
    test_frame(8'h55, 1'b0, "single");
    test_frame(8'hA3, 1'b1, "stall");
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
